// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall control for a five-stage pipeline.
// Detects load-use hazards and hazards on branches resolved in ID.
// Handles memory freezes and counts stall cycles.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal issue; evaluates hazards against the EX/MEM producers
// STALL | second bubble of a branch-after-load; hazard inputs ignored
module hazard_stall_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    input  logic             Uses_Rt_IF_ID,
    input  logic             Branch_IF_ID,
    input  logic             Branch_Taken,
    input  logic [4:0]       Dest_ID_EX,
    input  logic             Reg_Write_ID_EX,
    input  logic             Mem_Read_ID_EX,
    input  logic [4:0]       Rd_EX_MEM,
    input  logic             Mem_Read_EX_MEM,
    input  logic             Mem_Req,
    input  logic             Mem_Ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Freeze,
    output logic             Mem_Error,
    output logic [CNT_W-1:0] Stall_Cycles
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Freeze counter is 8 bits wide because TIMEOUT never exceeds 255.
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [1:0]       scnt_q, scnt_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             match_ex;
    logic             match_mem;
    logic [1:0]       need;

    // Register zero never creates a dependency.
    function automatic logic reg_match(input logic [4:0] r,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    // Operand matches against the EX and MEM producers.
    always_comb begin
        match_ex  = reg_match(Dest_ID_EX, Rs_IF_ID, Rt_IF_ID, Uses_Rt_IF_ID);
        match_mem = reg_match(Rd_EX_MEM, Rs_IF_ID, Rt_IF_ID, Uses_Rt_IF_ID);
    end

    // Number of bubbles the ID instruction needs, highest priority first.
    always_comb begin
        need = 2'd0;
        if (Mem_Read_ID_EX && match_ex) begin
            need = Branch_IF_ID ? 2'd2 : 2'd1;
        end else if (Branch_IF_ID && Reg_Write_ID_EX && match_ex) begin
            need = 2'd1;
        end else if (Branch_IF_ID && Mem_Read_EX_MEM && match_mem) begin
            need = 2'd1;
        end
    end

    // Next state and pipeline control outputs.
    // A freeze takes priority over everything and holds the stall sequence.
    always_comb begin
        state_d      = state_q;
        scnt_d       = scnt_q;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Freeze       = 1'b0;
        if (!rst) begin
            if (Mem_Req && !Mem_Ready) begin
                Freeze      = 1'b1;
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (need != 2'd0) begin
                            PC_Write     = 1'b0;
                            IF_ID_Write  = 1'b0;
                            ID_EX_Bubble = 1'b1;
                            if (need == 2'd2) begin
                                state_d = STALL;
                                scnt_d  = 2'd1;
                            end
                        end else begin
                            IF_ID_Flush = Branch_Taken;
                        end
                    end
                    STALL: begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        scnt_d       = scnt_q - 2'd1;
                        if (scnt_d == 2'd0) begin
                            state_d = RUN;
                        end
                    end
                    default: begin
                        state_d = RUN;
                        scnt_d  = 2'd0;
                    end
                endcase
            end
        end
    end

    // Consecutive-freeze counter, sticky timeout flag and saturating stall counter.
    always_comb begin
        fcnt_d      = 8'd0;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        if (Freeze) begin
            fcnt_d = (fcnt_q == 8'hFF) ? fcnt_q : fcnt_q + 8'd1;
            if (fcnt_q == TIMEOUT_M1) begin
                mem_err_d = 1'b1;
            end
        end
        if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            scnt_q      <= 2'd0;
            fcnt_q      <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            fcnt_q      <= fcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Mem_Error    = mem_err_q;
    assign Stall_Cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus
// randomized traffic compared against a cycle-count reference model.
module tb_hazard_stall_unit;

    localparam int TO   = 4;
    localparam int CW   = 6;
    localparam int SMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    rs, rt, dex, dmem;
    logic          urt, br, bt, rwex, mrex, mrmem, mreq, mrdy;
    logic          pc_w, ifid_w, ifid_fl, bub, frz, merr;
    logic [CW-1:0] scyc;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending extra bubbles, freeze run length, flags.
    int m_extra, m_frz, m_err, m_sc;

    hazard_stall_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .Rs_IF_ID        (rs),
        .Rt_IF_ID        (rt),
        .Uses_Rt_IF_ID   (urt),
        .Branch_IF_ID    (br),
        .Branch_Taken    (bt),
        .Dest_ID_EX      (dex),
        .Reg_Write_ID_EX (rwex),
        .Mem_Read_ID_EX  (mrex),
        .Rd_EX_MEM       (dmem),
        .Mem_Read_EX_MEM (mrmem),
        .Mem_Req         (mreq),
        .Mem_Ready       (mrdy),
        .PC_Write        (pc_w),
        .IF_ID_Write     (ifid_w),
        .IF_ID_Flush     (ifid_fl),
        .ID_EX_Bubble    (bub),
        .Freeze          (frz),
        .Mem_Error       (merr),
        .Stall_Cycles    (scyc)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_match(input logic [4:0] r);
        return (r != 0) && ((r == rs) || (urt && (r == rt)));
    endfunction

    function automatic int m_need();
        if (mrex && m_match(dex) && br) return 2;
        if (mrex && m_match(dex)) return 1;
        if (br && rwex && m_match(dex)) return 1;
        if (br && mrmem && m_match(dmem)) return 1;
        return 0;
    endfunction

    task automatic idle();
        rst = 0; rs = 0; rt = 0; dex = 0; dmem = 0;
        urt = 0; br = 0; bt = 0; rwex = 0; mrex = 0; mrmem = 0;
        mreq = 0; mrdy = 0;
    endtask

    // Called one time unit after a rising edge with inputs already driven.
    // Checks combinational outputs against the model, then clocks once.
    task automatic step();
        int need, e_pc, e_fl, e_bub, e_frz;
        #2;
        need  = m_need();
        e_frz = 0; e_pc = 1; e_fl = 0; e_bub = 0;
        if (!rst) begin
            if (mreq && !mrdy) begin
                e_frz = 1; e_pc = 0;
            end else if (m_extra > 0 || need > 0) begin
                e_pc = 0; e_bub = 1;
            end else begin
                e_fl = bt;
            end
        end
        check_eq("PC_Write", int'(pc_w), e_pc);
        check_eq("IF_ID_Write", int'(ifid_w), e_pc);
        check_eq("IF_ID_Flush", int'(ifid_fl), e_fl);
        check_eq("ID_EX_Bubble", int'(bub), e_bub);
        check_eq("Freeze", int'(frz), e_frz);
        @(posedge clk);
        if (rst) begin
            m_extra = 0; m_frz = 0; m_err = 0; m_sc = 0;
        end else begin
            if (e_frz == 1) begin
                m_frz++;
                if (m_frz == TO) m_err = 1;
            end else begin
                m_frz = 0;
                if (m_extra > 0) m_extra--;
                else if (need == 2) m_extra = 1;
            end
            if (e_pc == 0 && m_sc < SMAX) m_sc++;
        end
        #1;
        check_eq("Mem_Error", int'(merr), m_err);
        check_eq("Stall_Cycles", int'(scyc), m_sc);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    int burst;

    initial begin
        m_extra = 0; m_frz = 0; m_err = 0; m_sc = 0;
        idle();
        rst = 1;
        @(posedge clk); #1;
        step();
        check_eq("reset_stall_cycles", int'(scyc), 0);
        check_eq("reset_mem_error", int'(merr), 0);
        rst = 0;

        // Load-use: one bubble.
        mrex = 1; dex = 5; rs = 5;
        #1; check_eq("lu_pc_write", int'(pc_w), 0);
        check_eq("lu_bubble", int'(bub), 1);
        step();
        idle();
        #1; check_eq("lu_resume", int'(pc_w), 1);
        step();
        check_eq("lu_stall_cycles", int'(scyc), 1);

        // Branch after load via Rt: two bubbles.
        do_reset();
        br = 1; mrex = 1; dex = 8; rt = 8; urt = 1;
        #1; check_eq("bl_first", int'(pc_w), 0);
        step();
        idle();
        #1; check_eq("bl_second", int'(pc_w), 0);
        check_eq("bl_second_bub", int'(bub), 1);
        step();
        #1; check_eq("bl_resume", int'(pc_w), 1);
        step();
        check_eq("bl_stall_cycles", int'(scyc), 2);

        // Register zero never stalls.
        do_reset();
        mrex = 1; dex = 0; rs = 0;
        #1; check_eq("r0_pc_write", int'(pc_w), 1);
        step();

        // Freeze inside STALL holds the remaining bubble.
        do_reset();
        br = 1; mrex = 1; dex = 3; rs = 3;
        step();
        mreq = 1; mrdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1; check_eq("fz_freeze", int'(frz), 1);
            step();
        end
        mreq = 0;
        #1; check_eq("fz_remaining", int'(bub), 1);
        step();
        idle();
        #1; check_eq("fz_resume", int'(pc_w), 1);
        step();
        check_eq("fz_stall_cycles", int'(scyc), 5);

        // Timeout: sticky after the TO-th frozen cycle.
        do_reset();
        mreq = 1; mrdy = 0;
        for (int i = 0; i < TO - 1; i++) step();
        check_eq("to_before", int'(merr), 0);
        step();
        check_eq("to_set", int'(merr), 1);
        mrdy = 1;
        step();
        check_eq("to_sticky", int'(merr), 1);
        do_reset();
        check_eq("to_cleared", int'(merr), 0);

        // Taken branch flushes only when no hazard.
        bt = 1;
        #1; check_eq("tb_flush", int'(ifid_fl), 1);
        step();
        mrex = 1; dex = 7; rs = 7;
        #1; check_eq("tb_flush_hazard", int'(ifid_fl), 0);
        step();
        idle();
        step();

        // Reset mid-STALL with hazard and freeze inputs present.
        br = 1; mrex = 1; dex = 9; rs = 9;
        step();
        rst = 1; mreq = 1;
        #1; check_eq("rst_pc_write", int'(pc_w), 1);
        check_eq("rst_freeze", int'(frz), 0);
        step();
        idle();
        #1; check_eq("rst_abort", int'(pc_w), 1);
        step();

        // Stall counter saturates.
        mreq = 1; mrdy = 0;
        for (int i = 0; i < SMAX + 6; i++) step();
        check_eq("sat_stall_cycles", int'(scyc), SMAX);
        do_reset();

        // Randomized traffic against the model.
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 149) == 0);
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            dex   = 5'($urandom_range(0, 3));
            dmem  = 5'($urandom_range(0, 3));
            urt   = 1'($urandom_range(0, 1));
            br    = 1'($urandom_range(0, 1));
            bt    = 1'($urandom_range(0, 1));
            rwex  = 1'($urandom_range(0, 1));
            mrex  = 1'($urandom_range(0, 1));
            mrmem = 1'($urandom_range(0, 1));
            if (burst > 0) begin
                mreq = 1; mrdy = 0; burst--;
            end else begin
                mreq = ($urandom_range(0, 7) == 0);
                mrdy = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 99) == 0) burst = $urandom_range(3, 7);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
